mem_io_bridge: RTL and testbench

- Responder side of the execute-stage address path: takes the byte address computed by the execute unit (its ALU result) plus load/store control, and services the access.
- Routes each access to the synchronous data RAM or to the memory-mapped IO window.
- Holds the CPU with `stall` until read data or write completion is ready.
- Sits between the execute unit, data RAM and the switch/LED/segment IO controllers.

---
 rtl/mem_io_bridge.sv | 165 ++++++++++++++++
 tb/tb_mem_io_bridge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: responder for execute-stage loads/stores.
// Each access goes either to the synchronous data RAM or to the memory-mapped
// IO window. The CPU is held with stall until read data or write completion is
// ready, and a one-cycle done pulse then returns the result.
// Optional build macro: MISALIGN_CHECK_EN. When it is defined, an access with a
// non-zero byte offset is rejected with err/done one cycle after accept and
// no RAM or IO access is issued.
module mem_io_bridge #(
    parameter int          RAM_AW  = 14,
    parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
    parameter int          TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_req,
    output logic              io_we,
    output logic [7:0]        io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM_ACC,
        S_RAM_RD,
        S_IO_WAIT,
        S_RESP
    } state_t;

    // Last IO_WAIT cycle before the access is abandoned.
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [RAM_AW-1:0] waddr_q, waddr_d;   // word address, addr_in[RAM_AW+1:2]
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;         // registered op: 1 = store
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [3:0]        cnt_q, cnt_d;

    logic accept;
    logic is_io;
    logic misalign;

    assign accept = (state_q == S_IDLE) && req_valid && (mem_read || mem_write);
    assign is_io  = (addr_in[31:10] == IO_BASE[31:10]);

`ifdef MISALIGN_CHECK_EN
    assign misalign = (addr_in[1:0] != 2'b00);
`else
    // Byte offset is ignored: the access uses the truncated word address.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_in[1:0];
    assign misalign        = 1'b0;
`endif

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state_q <= S_IDLE;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: request capture, RAM/IO sequencing and timeout.
    always_comb begin
        // NOTE: every next-state value is defaulted to hold first, so no path
        // through the case leaves a signal unassigned (no latch inferred).
        state_d = state_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    waddr_d = addr_in[RAM_AW+1:2];
                    wdata_d = wdata;
                    we_d    = mem_write;   // read+write together is a write
                    err_d   = 1'b0;
                    if (misalign) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (is_io) begin
                        state_d = S_IO_WAIT;
                    end else begin
                        state_d = S_RAM_ACC;
                    end
                end
            end
            S_RAM_ACC: state_d = we_q ? S_RESP : S_RAM_RD;
            S_RAM_RD: begin
                rdata_d = ram_rdata;
                state_d = S_RESP;
            end
            S_IO_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (io_ack) begin
                    // An ack in the final wait cycle still counts as success.
                    rdata_d = we_q ? 32'd0 : io_rdata;
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stall     = accept || ((state_q != S_IDLE) && (state_q != S_RESP));
    assign done      = (state_q == S_RESP);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign ram_en    = (state_q == S_RAM_ACC);
    assign ram_we    = ram_en && we_q;
    assign ram_addr  = waddr_q;
    assign ram_wdata = wdata_q;
    assign io_req    = (state_q == S_IO_WAIT);
    assign io_we     = io_req && we_q;
    assign io_addr   = waddr_q[7:0];
    assign io_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: directed bench for mem_io_bridge. Each request pushes its
// expected result (rdata, err, done cycle) into a scoreboard; a monitor pops
// and compares whenever done is presented. A small RAM model and a driven
// io_ack stand in for the data RAM and IO controllers.
module tb_mem_io_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, mem_read, mem_write;
    logic [31:0] addr_in, wdata;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        ram_en, ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        io_req, io_we;
    logic [7:0]  io_addr;
    logic [31:0] io_wdata, io_rdata;
    logic        io_ack;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] mem [0:255];

`ifdef MISALIGN_CHECK_EN
    localparam logic [31:0] MIS_RD = 32'h0;
`else
    localparam logic [31:0] MIS_RD = 32'hCAFE_F00D;
`endif

    mem_io_bridge dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
        .addr_in(addr_in), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .err(err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous RAM model: read-first, one cycle latency after ram_en.
    always @(posedge clock) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr[7:0]];
            if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each completion against the oldest expectation.
    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rdata", rdata, mon_e.rdata);
                check("err", 32'(err), 32'(mon_e.err));
                check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    // One access: drive the request, push its expectation, then watch
    // stall/io_req/ram_en until done, bounded by a cycle budget.
    task automatic run_op(input string nm, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int lat, input int ack_at, input logic [31:0] io_d,
                          input int exp_ioreq, input int exp_ren,
                          input logic [31:0] exp_af, input logic exp_we,
                          input logic hold);
        int          a;
        int          n_st;
        int          n_io;
        int          n_ren;
        logic        seen;
        logic [31:0] got_af;
        logic        got_we;
        exp_t        e;
        n_st = 0; n_io = 0; n_ren = 0; seen = 1'b0; got_af = '0; got_we = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b1; mem_read = rd; mem_write = wr;
        addr_in = addr; wdata = wd; io_rdata = io_d; io_ack = 1'b0;
        a = cyc;
        e.rdata = exp_rd; e.err = exp_err; e.cyc = a + lat;
        sb.push_back(e);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            if (stall) n_st++;
            if (io_req) begin n_io++; got_af = 32'(io_addr); got_we = io_we; end
            if (ram_en) begin n_ren++; got_af = 32'(ram_addr); got_we = ram_we; end
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clock); #1;
                if (!hold) begin req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; end
                io_ack = (ack_at > 0) && (cyc == a + ack_at);
            end
        end
        io_ack = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        check({nm, "_done_seen"}, 32'(seen), 32'd1);
        check({nm, "_stall_cycles"}, 32'(n_st), 32'(lat));
        check({nm, "_io_req_cycles"}, 32'(n_io), 32'(exp_ioreq));
        check({nm, "_ram_en_cycles"}, 32'(n_ren), 32'(exp_ren));
        if (exp_ioreq + exp_ren > 0) begin
            check({nm, "_addr"}, got_af, exp_af);
            check({nm, "_we"}, 32'(got_we), 32'(exp_we));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr_in = '0; wdata = '0; io_rdata = '0; io_ack = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ram", {ram_wdata[15:0], 2'(ram_addr[1:0]), 12'(ram_addr[13:2]), ram_en, ram_we}, 32'd0);
        check("rst_io", {io_wdata[21:0], io_addr, io_req, io_we}, 32'd0);

        //      name        rd    wr    addr           wdata          exp_rdata      err lat ack io_data        io  ren addr field   we  hold
        run_op("ram_wr",    1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0,  2,  0, 32'h0,         0,  1,  32'd4,       1,  0);
        run_op("ram_rd",    1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0,  3,  0, 32'h0,         0,  1,  32'd4,       0,  1);
        run_op("io_rd",     1'b1, 1'b0, 32'hFFFF_FC60, 32'h0,         32'h0000_00A5, 0,  5,  4, 32'h0000_00A5, 4,  0,  32'h18,      0,  0);
        run_op("ram_top",   1'b0, 1'b1, 32'hFFFF_FBFC, 32'h1234_5678, 32'h0000_00A5, 0,  2,  0, 32'h0,         0,  1,  32'h3EFF,    1,  0);
        run_op("io_tmo",    1'b0, 1'b1, 32'hFFFF_FC00, 32'h1111_2222, 32'h0,         1,  16, 0, 32'h0,         15, 0,  32'h0,       1,  0);
        run_op("io_ack_tm", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0077, 0,  16, 15, 32'h0000_0077, 15, 0, 32'hFF,      0,  0);
        run_op("io_wr",     1'b0, 1'b1, 32'hFFFF_FC08, 32'h0000_0055, 32'h0,         0,  2,  1, 32'hFFFF_FFFF, 1,  0,  32'h2,       1,  0);
        run_op("ram_wrap",  1'b0, 1'b1, 32'h0001_0010, 32'hCAFE_F00D, 32'h0,         0,  2,  0, 32'h0,         0,  1,  32'd4,       1,  0);
        run_op("rd_top",    1'b1, 1'b0, 32'hFFFF_FBFC, 32'h0,         32'h1234_5678, 0,  3,  0, 32'h0,         0,  1,  32'h3EFF,    0,  0);
        run_op("rd_wrap",   1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 0,  3,  0, 32'h0,         0,  1,  32'd4,       0,  0);
`ifdef MISALIGN_CHECK_EN
        run_op("misalign",  1'b1, 1'b0, 32'h0000_0012, 32'h0,         32'h0,         1,  1,  0, 32'h0,         0,  0,  32'h0,       0,  0);
`else
        run_op("misalign",  1'b1, 1'b0, 32'h0000_0012, 32'h0,         32'hCAFE_F00D, 0,  3,  0, 32'h0,         0,  1,  32'd4,       0,  0);
`endif

        // req_valid without an op bit must be ignored.
        @(posedge clock); #1;
        req_valid = 1'b1; addr_in = 32'h0000_0010;
        @(negedge clock);
        check("noop_stall", 32'(stall), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("noop_idle", {29'd0, stall, ram_en, io_req}, 32'd0);
        @(posedge clock); #1 req_valid = 1'b0;

        // Read and write together behaves as a store.
        run_op("rd_and_wr", 1'b1, 1'b1, 32'h0000_0020, 32'h0000_ABCD, MIS_RD,        0,  2,  0, 32'h0,         0,  1,  32'd8,       1,  0);

        // Reset during IO_WAIT aborts the access without a done pulse.
        @(posedge clock); #1;
        req_valid = 1'b1; mem_read = 1'b1; addr_in = 32'hFFFF_FC04;
        @(posedge clock); #1;
        req_valid = 1'b0; mem_read = 1'b0;
        @(negedge clock);
        check("abort_io_req_before", 32'(io_req), 32'd1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("abort_io_req", 32'(io_req), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        run_op("post_rst",  1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_ABCD, 0,  3,  0, 32'h0,         0,  1,  32'd8,       0,  0);

        repeat (4) @(posedge clock);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
